// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-side arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam int BURST_MAX_DEF = 8;
  localparam int BEAT_W        = 8;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority selector: first set request searching upward from rr_last+1.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_last,
  output logic [NREQ-1:0] pick,
  output logic [IW-1:0]   pick_idx
);

  logic [IW-1:0] idx;

  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    pick     = '0;
    pick_idx = '0;
    idx      = '0;
    // Walk from the lowest priority to the highest; the last hit wins.
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(rr_last) + k) % NREQ);
      if (req[idx]) begin
        pick      = '0;
        pick[idx] = 1'b1;
        pick_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter granting bursts of FIFO writes to one of NREQ requesters.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int NREQ      = 4,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic                   wclk,
  input  logic                   wrst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  input  logic                   wfull,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        ack,
  output logic                   fifowr,
  output logic [DWIDTH-1:0]      wdata,
  output logic [BEAT_W-1:0]      beat_cnt
);

  localparam int IW = idx_w(NREQ);

  state_t            state;
  logic [IW-1:0]     rr_last;
  logic [NREQ-1:0]   pick;
  logic [IW-1:0]     pick_idx;
  logic              own_req;
  logic              last_beat;
  logic [BEAT_W-1:0] beat_nxt;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req      (req),
    .rr_last  (rr_last),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  // rr_last doubles as the owner index while in XFER.
  assign own_req   = req[rr_last];
  assign fifowr    = (state == XFER) & own_req & ~wfull;
  assign ack       = fifowr ? gnt : '0;
  assign wdata     = (state == XFER) ? req_data[rr_last*DWIDTH +: DWIDTH] : '0;
  assign beat_nxt  = beat_cnt + 1'b1;
  assign last_beat = (beat_nxt == BEAT_W'(BURST_MAX));

  // NOTE: registers use <= so every branch sees the pre-edge values of state and counters.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state    <= IDLE;
      gnt      <= '0;
      beat_cnt <= '0;
      rr_last  <= IW'(NREQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state    <= XFER;
            gnt      <= pick;
            rr_last  <= pick_idx;
            beat_cnt <= '0;
          end else begin
            gnt <= '0;
          end
        end
        XFER: begin
          if (!own_req) begin
            state <= IDLE;
            gnt   <= '0;
          end else if (fifowr) begin
            beat_cnt <= beat_nxt;
            if (last_beat) begin
              state <= IDLE;
              gnt   <= '0;
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter DWIDTH, default 32: FIFO write data width.
REQ-002 Parameter NREQ, default 4: number of requesters (2..8).
REQ-003 Parameter BURST_MAX, default 8: maximum accepted beats per grant (1..255).
REQ-004 wclk  input  1  sole clock; all state updates on rising edge.
REQ-005 wrst  input  1  asynchronous, active-high reset.
REQ-006 req  input  NREQ  per-requester write request, level, held while data pending.
REQ-007 req_data  input  NREQ*DWIDTH  per-requester data; requester i occupies bits [i*DWIDTH +: DWIDTH].
REQ-008 wfull  input  1  FIFO write-side full flag.
REQ-009 gnt  output  NREQ  one-hot registered grant; all-zero when no owner.
REQ-010 ack  output  NREQ  one-hot beat-accepted strobe; requester advances its data when its bit is set.
REQ-011 fifowr  output  1  FIFO write enable.
REQ-012 wdata  output  DWIDTH  FIFO write data.
REQ-013 beat_cnt  output  8  accepted beats in the current grant.

Function
REQ-014 FSM states: IDLE, XFER; state, gnt, beat_cnt, and rr_last are registered.
REQ-015 IDLE with req != 0 -> XFER next cycle; gnt = first requester with req set, searching upward from rr_last+1 modulo NREQ; rr_last <= that index.
REQ-016 IDLE with req == 0 -> stay IDLE; gnt = 0.
REQ-017 In XFER, fifowr = req[owner] & ~wfull, combinational, same cycle.
REQ-018 wdata = req_data slice of the owner whenever the state is XFER; 0 in IDLE.
REQ-019 ack[owner] = fifowr; all other ack bits 0; ack never asserted in IDLE.
REQ-020 beat_cnt increments by 1 on each accepted beat; it is cleared on entry to XFER.
REQ-021 XFER -> IDLE on an accepted beat that makes beat_cnt reach BURST_MAX.
REQ-022 XFER -> IDLE in any cycle where req[owner] is 0; no write occurs in that cycle.
REQ-023 On either XFER -> IDLE exit, gnt clears on the next edge.
REQ-024 Turnaround cost: one IDLE cycle between grants.
REQ-025 First-beat latency: req seen in IDLE at edge N -> gnt and first possible fifowr in cycle N+1.
REQ-026 wfull high in XFER: no write, no ack, beat_cnt holds, grant holds.
REQ-027 Full-stall cycles do not count toward BURST_MAX.
REQ-028 Non-owner requests have no effect during XFER.
REQ-029 Round-robin fairness: after a burst ends, the previous owner has lowest priority at the next arbitration.
REQ-030 fifowr is never asserted while wfull is 1; no beat is lost or duplicated.

Reset
REQ-031 wrst high immediately (asynchronously) forces: state = IDLE, gnt = 0, beat_cnt = 0, rr_last = NREQ-1.
REQ-032 Consequently, during reset, fifowr = 0, ack = 0, and wdata = 0.
REQ-033 Reset mid-burst abandons the burst; requester 0 has top priority after release.
REQ-034 The first arbitration occurs on the first rising edge with wrst low.

Structure
REQ-035 Package fifo_arb_pkg holds the FSM state enum, the BURST_MAX default, and the beat_cnt width constant.
REQ-036 Sub-module rr_pick: combinational rotating-priority selector (inputs req and rr_last, outputs one-hot pick and its index), instantiated once.

Verification
REQ-037 Single requester: req=4'b0001, wfull=0, data 0xA0..0xA9 -> 8 writes (0xA0..0xA7), IDLE, regrant, then 0xA8, 0xA9.
REQ-038 All four requesting continuously, BURST_MAX=8: grant order 0,1,2,3,0; 8 writes per grant; exactly one idle cycle between grants.
REQ-039 wfull raised for 5 cycles after beat 3: fifowr=0 and ack=0 for those 5 cycles; beat_cnt holds at 3; beats 4..8 follow; no data lost.
REQ-040 Owner 2 drops req after 2 beats: gnt clears next edge; requester 3 is granted after 1 idle cycle.
REQ-041 wrst asserted mid-burst (beat 4 of requester 1): gnt, ack, fifowr drop to 0 without a clock edge; after release with req=4'b0011, requester 0 is granted first.
